// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared ioctl bus types and constants for player and receiver blocks
package ioctl_pkg;

    localparam int IOCTL_ADDR_W = 25;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        ARM,
        WRITE,
        GAP,
        FINISH
    } ioctl_player_state_t;

endpackage

// File: rtl/ioctl_player_if.sv
// rtl/ioctl_player_if.sv - ioctl download bus between an initiator (master) and a receiver (slave)
interface ioctl_player_if #(
    parameter int ADDR_W = 25
) ();

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic              ioctl_wait;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output ioctl_index,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  ioctl_index,
        output ioctl_wait
    );

endinterface

// File: rtl/ioctl_player.sv
// rtl/ioctl_player.sv - streams a source-buffer image onto the ioctl download bus
// IOCTL_PLAYER_GAP_EN adds GAP_CYCLES idle cycles after every write.
module ioctl_player
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = IOCTL_ADDR_W
`ifdef IOCTL_PLAYER_GAP_EN
    ,
    parameter int GAP_CYCLES = 3
`endif
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index_in,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_rd,
    input  logic [7:0]        src_data,
    ioctl_player_if.master    bus,
    output logic              busy,
    output logic              done
);

    ioctl_player_state_t state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] length_q, length_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              src_rd_q, src_rd_d;
    logic              download_q, download_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        index_q, index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef IOCTL_PLAYER_GAP_EN
    logic [7:0]        gap_q, gap_d;
`endif

    logic [ADDR_W-1:0] count_inc;
    logic              adv;
    logic [ADDR_W-1:0] adv_cnt;

    assign count_inc = count_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        length_d   = length_q;
        src_addr_d = src_addr_q;
        src_rd_d   = 1'b0;
        download_d = download_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        dout_d     = dout_q;
        index_d    = index_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        adv        = 1'b0;
        adv_cnt    = count_q;
`ifdef IOCTL_PLAYER_GAP_EN
        gap_d      = gap_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d    = SETUP;
                        index_d    = index_in;
                        length_d   = length;
                        count_d    = '0;
                        busy_d     = 1'b1;
                        download_d = 1'b1;
                        src_rd_d   = 1'b1;
                        src_addr_d = '0;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            SETUP: state_d = FETCH;
            FETCH: begin
                dout_d  = src_data;
                addr_d  = count_q;
                state_d = ARM;
            end
            ARM: begin
                if (!bus.ioctl_wait) begin
                    wr_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                count_d = count_inc;
`ifdef IOCTL_PLAYER_GAP_EN
                gap_d   = 8'(GAP_CYCLES - 1);
                state_d = GAP;
`else
                adv     = 1'b1;
                adv_cnt = count_inc;
`endif
            end
`ifdef IOCTL_PLAYER_GAP_EN
            GAP: begin
                if (gap_q == 8'd0) begin
                    adv = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
`endif
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Leaving a byte: either fetch the next one or close the window
        if (adv) begin
            if (adv_cnt == length_q) begin
                state_d    = FINISH;
                done_d     = 1'b1;
                download_d = 1'b0;
                busy_d     = 1'b0;
            end else begin
                state_d    = SETUP;
                src_rd_d   = 1'b1;
                src_addr_d = adv_cnt;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            length_q   <= '0;
            src_addr_q <= '0;
            src_rd_q   <= 1'b0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            index_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IOCTL_PLAYER_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            length_q   <= length_d;
            src_addr_q <= src_addr_d;
            src_rd_q   <= src_rd_d;
            download_q <= download_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            index_q    <= index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef IOCTL_PLAYER_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign src_addr           = src_addr_q;
    assign src_rd             = src_rd_q;
    assign bus.ioctl_download = download_q;
    assign bus.ioctl_wr       = wr_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;
    assign bus.ioctl_index    = index_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_ioctl_player.sv
// tb/tb_ioctl_player.sv - table-driven checks of ioctl_player transfers, stalls, restarts and reset
module tb_ioctl_player;
    import ioctl_pkg::*;

    localparam int AW = IOCTL_ADDR_W;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    index_in = 8'h00;
    logic [AW-1:0] length = '0;
    logic [AW-1:0] src_addr;
    logic          src_rd;
    logic [7:0]    src_data = 8'h00;
    logic          busy;
    logic          done;

    ioctl_player_if #(.ADDR_W(AW)) bus ();

    ioctl_player #(.ADDR_W(AW)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (start),
        .index_in (index_in),
        .length   (length),
        .src_addr (src_addr),
        .src_rd   (src_rd),
        .src_data (src_data),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] rom [16];

    always @(posedge clk_sys) src_data <= src_rd ? rom[src_addr[3:0]] : 8'h00;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int         len;
        logic [7:0] idx;
        int         wait_from;
        int         wait_len;
        bit         spam;
        logic [7:0] exp_index;
        int         exp_last_wr;
        int         exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input string tag, input vec_t v);
        int k, nwr, nrd, done_cyc, last_wr, prev_wr;
        bit seen_done, dl_ok, busy_ok, rd_ok, spacing_ok, tail_ok, prev_wr_hi;
        nwr = 0; nrd = 0; done_cyc = -1; last_wr = 0; prev_wr = 0;
        seen_done = 0; dl_ok = 1; busy_ok = 1; rd_ok = 1; spacing_ok = 1; tail_ok = 1;
        prev_wr_hi = 0;
        @(negedge clk_sys);
        index_in = v.idx;
        length   = AW'(v.len);
        start    = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        k = 1;
        while (!seen_done && k <= 200) begin
            bus.ioctl_wait = (k >= v.wait_from && k < v.wait_from + v.wait_len);
            if (bus.ioctl_wr) begin
                check($sformatf("%s wr%0d addr", tag, nwr), bus.ioctl_addr, nwr);
                check($sformatf("%s wr%0d data", tag, nwr), bus.ioctl_dout, rom[nwr[3:0]]);
                if (v.wait_len == 0 && nwr > 0 && k - prev_wr != 4) spacing_ok = 0;
                prev_wr = k;
                last_wr = k;
                nwr++;
            end
            if (src_rd) begin
                nrd++;
                if (!(k == 1 || prev_wr_hi)) rd_ok = 0;
            end
            if (done) begin
                seen_done = 1;
                done_cyc  = k;
                if (bus.ioctl_download) dl_ok = 0;
                if (busy) busy_ok = 0;
            end else begin
                if (bus.ioctl_download != (v.len != 0)) dl_ok = 0;
                if (busy != (v.len != 0)) busy_ok = 0;
            end
            prev_wr_hi = bus.ioctl_wr;
            start = v.spam && (done || (k % 3 == 0));
            @(negedge clk_sys);
            start = 1'b0;
            k++;
        end
        bus.ioctl_wait = 1'b0;
        check($sformatf("%s done_seen", tag), seen_done, 1);
        for (int t = 0; t < 6; t++) begin
            if (done || bus.ioctl_wr || bus.ioctl_download || src_rd || busy) tail_ok = 0;
            @(negedge clk_sys);
        end
        check($sformatf("%s done_cycle", tag), done_cyc, v.exp_done);
        check($sformatf("%s last_wr_cycle", tag), last_wr, v.exp_last_wr);
        check($sformatf("%s wr_count", tag), nwr, v.len);
        check($sformatf("%s rd_count", tag), nrd, v.len);
        check($sformatf("%s index", tag), bus.ioctl_index, v.exp_index);
        check($sformatf("%s download_window", tag), dl_ok, 1);
        check($sformatf("%s busy_window", tag), busy_ok, 1);
        check($sformatf("%s rd_placement", tag), rd_ok, 1);
        check($sformatf("%s wr_spacing", tag), spacing_ok, 1);
        check($sformatf("%s quiet_after_done", tag), tail_ok, 1);
    endtask

    initial begin
        vec_t rv;
        int k;
        bit seen2;
        for (int i = 0; i < 16; i++) rom[i] = 8'(8'h11 * i + 8'h05);
        rom[0] = 8'hAA; rom[1] = 8'hBB; rom[2] = 8'hCC; rom[3] = 8'hDD;
        bus.ioctl_wait = 1'b0;

        //               len idx    wfrom wlen spam exp_idx last done
        vecs[0] = '{4, 8'h02,  0,  0, 1'b0, 8'h02, 16, 17};
        vecs[1] = '{4, 8'h02,  7, 10, 1'b0, 8'h02, 26, 27};
        vecs[2] = '{4, 8'h5A,  8,  5, 1'b0, 8'h5A, 18, 19};
        vecs[3] = '{0, 8'h33,  0,  0, 1'b0, 8'h5A,  0,  1};
        vecs[4] = '{1, 8'h01,  0,  0, 1'b0, 8'h01,  4,  5};
        vecs[5] = '{7, 8'h7F,  0,  0, 1'b0, 8'h7F, 28, 29};
        vecs[6] = '{4, 8'h44,  0,  0, 1'b1, 8'h44, 16, 17};

        repeat (3) @(negedge clk_sys);
        check("reset bus outputs",
              {bus.ioctl_download, bus.ioctl_wr, bus.ioctl_addr, bus.ioctl_dout, bus.ioctl_index}, 0);
        check("reset side outputs", {src_rd, src_addr, busy, done}, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset in the middle of an 8-byte transfer, right after the second write
        @(negedge clk_sys);
        index_in = 8'h66; length = AW'(8); start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        k = 1; seen2 = 0;
        while (!seen2 && k <= 50) begin
            if (bus.ioctl_wr && bus.ioctl_addr == AW'(1)) seen2 = 1;
            @(negedge clk_sys);
            k++;
        end
        check("mid reset second write seen", seen2, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("mid reset bus outputs",
              {bus.ioctl_download, bus.ioctl_wr, bus.ioctl_addr, bus.ioctl_dout, bus.ioctl_index}, 0);
        check("mid reset side outputs", {src_rd, src_addr, busy, done}, 0);
        reset = 1'b0;
        seen2 = 0;
        repeat (8) begin
            if (done || bus.ioctl_download || bus.ioctl_wr) seen2 = 1;
            @(negedge clk_sys);
        end
        check("mid reset stays idle", seen2, 0);
        rv = '{2, 8'h77, 0, 0, 1'b0, 8'h77, 8, 9};
        run_vec("restart", rv);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ioctl_player.md
# ioctl_player

Core-side initiator for the ioctl download bus: streams a byte image from a local source buffer onto `ioctl_download` / `ioctl_wr` / `ioctl_addr` / `ioctl_dout` / `ioctl_index`, honouring `ioctl_wait` from the receiver. It is the transmitting end of the same interface the simulation top consumes. It lets `system` (through its `dn_*` port) be loaded by a synthesizable or simulated source rather than by the HPS. It sits between a source ROM/RAM and any ioctl receiver.

## Interface
Parameters:
- `ADDR_W`, 25 — width of `ioctl_addr`, `length` and `src_addr`.
- `GAP_CYCLES`, 3 — idle cycles after each write; used only when `IOCTL_PLAYER_GAP_EN` is defined; legal range 1..255.

Ports:
- `clk_sys`  in  1 — the only clock.
- `reset`  in  1 — synchronous, active-high.
- `start`  in  1 — one-cycle request to begin a transfer.
- `index_in`  in  8 — image index; latched on an accepted `start`.
- `length`  in  `ADDR_W` — byte count; latched on an accepted `start`.
- `src_addr`  out  `ADDR_W` — source buffer read address.
- `src_rd`  out  1 — source read strobe.
- `src_data`  in  8 — source data, valid exactly 1 cycle after `src_rd`.
- `ioctl_download`  out  1 — transfer window.
- `ioctl_wr`  out  1 — one-cycle write strobe.
- `ioctl_addr`  out  `ADDR_W` — address of the byte being written.
- `ioctl_dout`  out  8 — data byte being written.
- `ioctl_index`  out  8 — latched `index_in`.
- `ioctl_wait`  in  1 — receiver back-pressure.
- `busy`  out  1 — high from an accepted `start` until `done`.
- `done`  out  1 — one-cycle completion pulse.

## Operation
- All outputs are registered. Every output resets to 0.
- States:
  - IDLE
    - `start` with `length`≠0 → SETUP; latch `index_in`, `length`, and set count = 0.
    - `start` with `length`=0 → `done` pulses the next cycle; `ioctl_download` is never asserted.
  - SETUP: `ioctl_download`=1, `src_rd`=1, `src_addr`=count → FETCH.
  - FETCH: capture `src_data` into `ioctl_dout`; `ioctl_addr`=count → ARM.
  - ARM
    - If `ioctl_wait`=0: `ioctl_wr`=1 next cycle → WRITE.
    - Otherwise stay in ARM; `ioctl_wr`=0 and `ioctl_dout`/`ioctl_addr` are held.
  - WRITE: `ioctl_wr` high for exactly this cycle; count+1.
    - Without the macro: count=length → FINISH; else → SETUP.
    - With the macro: always → GAP.
  - GAP (macro only): wait `GAP_CYCLES` cycles, then FINISH if count=length, else SETUP.
  - FINISH: `ioctl_download`=0, `done`=1 for one cycle, `busy`=0 → IDLE.
- `ioctl_download` stays continuously high from SETUP of byte 0 through the last WRITE (and its GAP).
- `ioctl_index` stays latched until the next accepted `start`.
- Count and address arithmetic is unsigned `ADDR_W`. `length` = 2^`ADDR_W`−1 is the maximum; there is no wrap.
- `start` while `busy` is ignored; a new `start` on the same cycle as `done` is also ignored.
- `ioctl_wait` rising during the WRITE cycle does not cancel that write; it stalls the next ARM.
- `reset` mid-transfer: on the next edge the FSM returns to IDLE and all outputs are 0. `ioctl_download` drops with no `done` pulse.

## Timing
- `start` at cycle 0 → `ioctl_download`/`src_rd` at cycle 1 → first `ioctl_wr` at cycle 4 when `ioctl_wait`=0.
- Throughput: 4 cycles/byte without the macro; 4+`GAP_CYCLES` cycles/byte with it.
- Last `ioctl_wr` at cycle T → `ioctl_download`=0 and `done`=1 at T+1 (T+1+`GAP_CYCLES` with the macro).
- `src_rd` is asserted exactly once per byte and never during ARM stalls.

## Configuration
- `IOCTL_PLAYER_GAP_EN`
  - Defined: GAP state present; `GAP_CYCLES` idle cycles after every write, including the last, mimicking HPS write spacing.
  - Undefined: GAP state and its counter are absent; `GAP_CYCLES` is ignored; back-to-back byte cadence.

## Structure
- Shared package `ioctl_pkg`: state enum `ioctl_player_state_t` (IDLE, SETUP, FETCH, ARM, WRITE, GAP, FINISH) and constant `IOCTL_ADDR_W`=25, shared with receiver-side blocks.
- Single flat module; no sub-module needed. The gap counter is inline.

## Test plan
- `length`=4, `index_in`=0x02, ROM bytes AA,BB,CC,DD, `ioctl_wait`=0 → four `ioctl_wr` pulses at addr 0..3 with matching data, every 4 cycles; `ioctl_index`=0x02; one `done`; `ioctl_download` high throughout.
- Same stimulus with `ioctl_wait` high for 10 cycles starting at the second ARM → byte 1 held with `ioctl_wr`=0 for 10 cycles; no `src_rd` during the stall; data still in order.
- `length`=0 → `done` at cycle 1; `ioctl_download`, `ioctl_wr` and `src_rd` never assert.
- `reset` asserted after the 2nd write of an 8-byte transfer → next cycle all outputs 0, no `done`; a subsequent `start` restarts at addr 0.
- `start` pulsed repeatedly while `busy` → ignored; exactly `length` writes and one `done`.
- With `IOCTL_PLAYER_GAP_EN`, `GAP_CYCLES`=3, `length`=2 → 7-cycle write spacing; `done` 4 cycles after the last `ioctl_wr`.
